// File: rtl/adder_share_arbiter.sv
// Two-requester arbiter in front of one shared 16-bit carry-select adder.
// Requests are accepted one at a time, the operands are registered, one EXEC
// cycle computes the sum, and the result is held in RESP until it is taken.

// 16-bit carry-select adder: four 4-bit blocks. Each block computes its
// result for both carry-in values, and the real incoming carry picks one.
module carry_select_adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_blk
      logic [4:0] res_c0;
      logic [4:0] res_c1;
      logic       c_in;
      logic       c_out;

      // Both candidate results; 15+15+1 still fits in 5 bits
      assign res_c0 = {1'b0, a[gi*4 +: 4]} + {1'b0, b[gi*4 +: 4]};
      assign res_c1 = res_c0 + 5'd1;

      if (gi == 0) begin : g_first
        assign c_in = cin;
      end else begin : g_rest
        assign c_in = g_blk[gi-1].c_out;
      end

      assign sum[gi*4 +: 4] = c_in ? res_c1[3:0] : res_c0[3:0];
      assign c_out          = c_in ? res_c1[4]   : res_c0[4];
    end
  endgenerate

  assign cout = g_blk[3].c_out;

endmodule

module adder_share_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             last_grant;
  logic             grant;
  logic             in_idle;
  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             op_id;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  // Grant from the current valids; on a tie the requester not served last wins
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Ready is only offered in IDLE and never while reset is asserted
  assign in_idle    = (state == IDLE) && rst_n;
  assign req0_ready = in_idle && req0_valid && !grant;
  assign req1_ready = in_idle && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;
  assign busy       = (state != IDLE);

  // The single shared adder only ever sees the registered operands
  carry_select_adder_16bit u_adder (
    .a    (op_a),
    .b    (op_b),
    .cin  (op_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Control FSM: capture operands, compute for one cycle, hold the response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
      op_cin     <= 1'b0;
      op_id      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_id     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a       <= grant ? req1_a   : req0_a;
            op_b       <= grant ? req1_b   : req0_b;
            op_cin     <= grant ? req1_cin : req0_cin;
            op_id      <= grant;
            last_grant <= grant;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_sum   <= add_sum;
          rsp_cout  <= add_cout;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: directed vector table, fixed sequences for
// tie-breaking, backpressure and reset abort, then a long random run against
// a queue-based reference model.
module tb_adder_share_arbiter;

  localparam int N_RAND = 10000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_cin;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin;
  logic [15:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
  logic [15:0] rsp_sum;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  adder_share_arbiter #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .busy       (busy)
  );

  typedef struct {
    logic        sel;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs[10];

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(7))
      0: rnd16 = 16'hFFFF;
      1: rnd16 = 16'h0000;
      2: rnd16 = 16'h8000;
      default: rnd16 = 16'($urandom);
    endcase
  endfunction

  // Starts at posedge+1, ends at posedge+1 right after the accept edge
  task automatic do_accept(input bit sel, input logic [15:0] a, input logic [15:0] b,
                           input logic cin);
    bit ok;
    if (sel) begin
      req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
    end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sel ? req1_ready : req0_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check_eq("accept_seen", 32'(ok), 32'd1);
    @(posedge clk); #1;
    if (sel) req1_valid = 1'b0;
    else req0_valid = 1'b0;
  endtask

  // Starts just after the accept edge, ends at the negedge where rsp_valid is seen
  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i;
        break;
      end
      if (i < 10) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic do_single(input bit sel, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, output int lat, output logic [15:0] s,
                           output logic c, output logic id);
    do_accept(sel, a, b, cin);
    wait_rsp(lat);
    s  = rsp_sum;
    c  = rsp_cout;
    id = rsp_id;
    @(posedge clk); #1;
  endtask

  initial begin
    int          lat;
    logic [15:0] s;
    logic        c, id;
    int          g_cnt;
    int          g_id[4];
    int          g_cyc[4];
    logic [16:0] q0[$];
    logic [16:0] q1[$];
    bit          pend0, pend1, hold;
    int          wait0, wait1, acc_cnt, rsp_cnt, issued;
    logic [18:0] held;
    logic [16:0] exp_v;

    vecs[0] = '{1'b0, 16'h1234, 16'h0FF0, 1'b0, 16'h2224, 1'b0};
    vecs[1] = '{1'b1, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1};
    vecs[2] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[4] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{1'b1, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
    vecs[6] = '{1'b0, 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0};
    vecs[7] = '{1'b1, 16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1};
    vecs[8] = '{1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};
    vecs[9] = '{1'b1, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state, with both requesters valid
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check_eq("reset_ready", {req0_ready, req1_ready}, 2'b00);
    check_eq("reset_busy_rspvalid", {busy, rsp_valid}, 2'b00);
    check_eq("reset_rsp", {rsp_id, rsp_cout, rsp_sum}, 18'h0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;

    // Continuous contention: grants alternate starting with req0, one accept per 3 cycles
    req0_a = 16'h1000; req0_b = 16'h0001; req0_cin = 1'b0;
    req1_a = 16'h2000; req1_b = 16'h0002; req1_cin = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    g_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      g_id[i] = -1;
      g_cyc[i] = -100;
    end
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      if (g_cnt < 4 && req0_valid && req0_ready) begin
        g_id[g_cnt] = 0; g_cyc[g_cnt] = cyc; g_cnt++;
      end else if (g_cnt < 4 && req1_valid && req1_ready) begin
        g_id[g_cnt] = 1; g_cyc[g_cnt] = cyc; g_cnt++;
      end
      if (rsp_valid)
        check_eq("tie_rsp_matches_id", {rsp_cout, rsp_sum}, rsp_id ? 17'h02002 : 17'h01001);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check_eq("tie_grant_count", g_cnt, 4);
    for (int i = 0; i < 4; i++) check_eq("tie_grant_id", g_id[i], i % 2);
    for (int i = 1; i < 4; i++) check_eq("tie_grant_spacing", g_cyc[i] - g_cyc[i-1], 3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!busy) break;
      @(posedge clk); #1;
    end
    check_eq("tie_drain_idle", busy, 1'b0);
    @(posedge clk); #1;

    // Directed vector table, one lone request at a time
    for (int v = 0; v < 10; v++) begin
      do_single(vecs[v].sel, vecs[v].a, vecs[v].b, vecs[v].cin, lat, s, c, id);
      $display("vec %0d: req%0d 0x%04h+0x%04h+%0d -> cout=%0d sum=0x%04h id=%0d lat=%0d",
               v, vecs[v].sel, vecs[v].a, vecs[v].b, vecs[v].cin, c, s, id, lat);
      check_eq("vec_latency", lat, 2);
      check_eq("vec_sum", s, vecs[v].sum);
      check_eq("vec_cout", c, vecs[v].cout);
      check_eq("vec_id", id, vecs[v].sel);
    end

    // Backpressure: result held, no readies while stalled, new request waits
    rsp_ready = 1'b0;
    do_single(1'b0, 16'h4321, 16'h1111, 1'b0, lat, s, c, id);
    check_eq("bp_first_rsp", {c, s}, 17'h05432);
    req1_a = 16'h0F0F; req1_b = 16'h0F0F; req1_cin = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("bp_stall", {rsp_valid, rsp_id, rsp_cout, rsp_sum, req0_ready, req1_ready, busy},
               {1'b1, 1'b0, 1'b0, 16'h5432, 1'b0, 1'b0, 1'b1});
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_no_accept_in_resp", req1_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("bp_idle_after", {busy, rsp_valid, req1_ready}, 3'b001);
    check_eq("bp_rsp_retained", rsp_sum, 16'h5432);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_rsp(lat);
    check_eq("bp_second_lat", lat, 2);
    check_eq("bp_second_rsp", {rsp_id, rsp_cout, rsp_sum}, {1'b1, 1'b0, 16'h1E1F});
    @(posedge clk); #1;

    // Reset during EXEC aborts the transaction
    do_accept(1'b0, 16'h8000, 16'h8000, 1'b0);
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("abort_reset_rsp", {rsp_valid, rsp_id, rsp_cout, rsp_sum}, 19'h0);
    check_eq("abort_reset_ready_busy", {req0_ready, req1_ready, busy}, 3'b000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("abort_no_rsp", {rsp_valid, busy}, 2'b00);
      @(posedge clk); #1;
    end
    do_single(1'b0, 16'h0001, 16'h0002, 1'b0, lat, s, c, id);
    check_eq("abort_next_lat", lat, 2);
    check_eq("abort_next_rsp", {id, c, s}, 18'h00003);

    // Random traffic against a queue-based reference model
    pend0 = 0; pend1 = 0; hold = 0; held = '0;
    wait0 = 0; wait1 = 0; acc_cnt = 0; rsp_cnt = 0; issued = 0;
    for (int cyc = 0; cyc < 90000 && rsp_cnt < N_RAND; cyc++) begin
      if (!pend0 && issued < N_RAND && $urandom_range(9) < 7) begin
        pend0 = 1; issued++; wait0 = 0;
        req0_a = rnd16(); req0_b = rnd16(); req0_cin = 1'($urandom_range(1));
      end
      if (!pend1 && issued < N_RAND && $urandom_range(9) < 7) begin
        pend1 = 1; issued++; wait1 = 0;
        req1_a = rnd16(); req1_b = rnd16(); req1_cin = 1'($urandom_range(1));
      end
      req0_valid = pend0;
      req1_valid = pend1;
      rsp_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        check_eq("rand_ready_exclusive", req0_ready & req1_ready, 1'b0);
        check_eq("rand_ready_needs_valid", {req0_ready & !req0_valid, req1_ready & !req1_valid}, 2'b00);
        check_eq("rand_one_outstanding", q0.size() + q1.size(), 0);
      end
      if (req0_valid && req0_ready) begin
        check_eq("rand_fair0", 32'(wait0 <= 1), 32'd1);
        q0.push_back({1'b0, req0_a} + {1'b0, req0_b} + {16'd0, req0_cin});
        pend0 = 0; acc_cnt++;
        if (pend1) wait1++;
      end
      if (req1_valid && req1_ready) begin
        check_eq("rand_fair1", 32'(wait1 <= 1), 32'd1);
        q1.push_back({1'b0, req1_a} + {1'b0, req1_b} + {16'd0, req1_cin});
        pend1 = 0; acc_cnt++;
        if (pend0) wait0++;
      end
      if (hold) check_eq("rand_rsp_stable", {rsp_valid, rsp_id, rsp_cout, rsp_sum}, held);
      hold = rsp_valid && !rsp_ready;
      held = {rsp_valid, rsp_id, rsp_cout, rsp_sum};
      if (rsp_valid && rsp_ready) begin
        if (rsp_id == 1'b0) begin
          check_eq("rand_rsp0_expected", 32'(q0.size() != 0), 32'd1);
          if (q0.size() != 0) begin
            exp_v = q0.pop_front();
            check_eq("rand_rsp0", {rsp_cout, rsp_sum}, exp_v);
          end
        end else begin
          check_eq("rand_rsp1_expected", 32'(q1.size() != 0), 32'd1);
          if (q1.size() != 0) begin
            exp_v = q1.pop_front();
            check_eq("rand_rsp1", {rsp_cout, rsp_sum}, exp_v);
          end
        end
        rsp_cnt++;
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    $display("random: %0d accepted, %0d responses", acc_cnt, rsp_cnt);
    check_eq("rand_accept_count", acc_cnt, N_RAND);
    check_eq("rand_rsp_count", rsp_cnt, N_RAND);
    check_eq("rand_queues_empty", q0.size() + q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
ADDER_SHARE_ARBITER -- requirements
Module: adder_share_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand/sum width; only 16 is supported (carry_select_adder_16bit datapath).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: req0_valid input 1, req0_ready output 1, req0_a input 16, req0_b input 16, req0_cin input 1: requester 0 add request.
REQ-005 SHALL have ports: req1_valid input 1, req1_ready output 1, req1_a input 16, req1_b input 16, req1_cin input 1: requester 1 add request.
REQ-006 SHALL have ports: rsp_valid output 1, rsp_ready input 1, rsp_id output 1 (granted requester), rsp_sum output 16, rsp_cout output 1: registered result.
REQ-007 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-008 SHALL contain exactly one instance of carry_select_adder_16bit, shared by both requesters; operands fed only from internal operand registers.
REQ-009 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-010 IDLE: reqN_ready = 1 only for the granted requester, both low if neither valid; other states: both ready low.
REQ-011 Grant: only one valid -> that one; both valid -> requester != last_grant; last_grant resets to 1 (req0 wins first tie).
REQ-012 Accept = granted reqN_valid & reqN_ready at an edge in IDLE: latch a, b, cin, id; update last_grant; IDLE -> EXEC.
REQ-013 EXEC lasts exactly one cycle: adder sum/cout registered into rsp_sum/rsp_cout, rsp_id from latched id; EXEC -> RESP.
REQ-014 RESP: rsp_valid = 1; rsp_sum, rsp_cout, rsp_id held stable until rsp_valid & rsp_ready at an edge, then RESP -> IDLE.
REQ-015 Latency: request accepted at edge N -> rsp_valid high from cycle after edge N+1 (2 cycles); rsp_ready held high gives 1 transaction per 3 cycles max.
REQ-016 Result arithmetic: {rsp_cout, rsp_sum} = a + b + cin, 17-bit, modulo 2^17 never exceeded; 0xFFFF+0xFFFF+1 = {1,0xFFFF}.
REQ-017 Response accepted and new request valid same cycle: no new accept that edge (ready low in RESP); accept earliest at next edge from IDLE.
REQ-018 Requester deasserting valid before accept: no transaction, no last_grant change; valid without ready SHALL NOT be lost (requester holds).
REQ-019 Grant SHALL be computed from current valids each IDLE cycle; a stalled requester under contention is served within 2 accepted transactions.
REQ-020 rsp_valid low in IDLE and EXEC; rsp_sum/rsp_cout/rsp_id retain last value outside RESP.

Reset
REQ-021 rst_n low at an edge: state IDLE, last_grant = 1, rsp_valid = 0, rsp_sum = 0, rsp_cout = 0, rsp_id = 0, busy = 0, operand regs = 0.
REQ-022 Reset in EXEC or RESP SHALL abort the transaction; no response for it after reset release.
REQ-023 While rst_n low: req0_ready = req1_ready = 0.

Verification
REQ-024 Single req0: a=0x1234, b=0x0FF0, cin=0, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_sum=0x2224, rsp_cout=0, rsp_id=0.
REQ-025 Overflow req1: a=0xFFFF, b=0x0001, cin=1 -> rsp_sum=0x0001, rsp_cout=1, rsp_id=1.
REQ-026 Both valid continuously after reset, rsp_ready=1 -> grants 0,1,0,1; accepts every 3 cycles; ids match operands.
REQ-027 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, both ready low, busy=1; rsp_ready=1 -> IDLE next cycle.
REQ-028 rst_n pulsed low during EXEC of a=0x8000,b=0x8000 -> rsp_valid never asserts for it; outputs at reset values; next request served normally.
REQ-029 Random: 10k requests, random valid/rsp_ready -> every response equals reference a+b+cin, no drops or duplicates, per-id order preserved.
